fpu_int_to_f32_pipe: RTL and testbench

Pipelined, parametrised integer-to-binary32 converter for the FPU datapath. It accepts a signed or unsigned integer of IN_WIDTH bits per transaction and returns an IEEE-754 single-precision result with an inexact flag. Two rounding modes are supported: round-to-nearest-even and round-toward-zero. Input and output use a valid/ready handshake with full backpressure. A caller-defined tag passes through alongside each result for out-of-order issue tracking.

---
 rtl/fpu_conv_pkg.sv | 19 +
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_int_to_f32_pipe.sv | 178 +++++++++++++++++
 tb/tb_fpu_int_to_f32_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_conv_pkg.sv
// rtl/fpu_conv_pkg.sv - shared types and constants for the integer/float converters
package fpu_conv_pkg;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rmode_e;

  localparam int F32_BIAS   = 127;
  localparam int F32_EXP_W  = 8;
  localparam int F32_FRAC_W = 23;

  typedef struct packed {
    logic                  sign;
    logic [F32_EXP_W-1:0]  exp;
    logic [F32_FRAC_W-1:0] frac;
  } f32_t;

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter
module fpu_lzc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] lz_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    lz_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) lz_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_int_to_f32_pipe.sv
// rtl/fpu_int_to_f32_pipe.sv - pipelined signed/unsigned integer to binary32 converter
module fpu_int_to_f32_pipe
  import fpu_conv_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [IN_WIDTH-1:0]  IN_A,
  input  logic                 IN_SIGNED,
  input  logic                 IN_RMODE,
  input  logic [TAG_WIDTH-1:0] IN_TAG,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_F,
  output logic                 OUT_INEXACT,
  output logic [TAG_WIDTH-1:0] OUT_TAG
);

  localparam int LZW = $clog2(IN_WIDTH + 1);
  // Normalised value padded so guard/sticky slices exist for any IN_WIDTH.
  localparam int EW  = IN_WIDTH + 26;

  logic en;

  logic                 in_valid_q;
  logic [IN_WIDTH-1:0]  in_a_q;
  logic                 in_signed_q;
  rmode_e               in_rm_q;
  logic [TAG_WIDTH-1:0] in_tag_q;

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [IN_WIDTH-1:0]  s1_mag_q;
  rmode_e               s1_rm_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic                 s1_sign_d;
  logic [IN_WIDTH-1:0]  s1_mag_d;

  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic [IN_WIDTH-1:0]  s2_norm_q;
  logic [F32_EXP_W-1:0] s2_exp_q;
  rmode_e               s2_rm_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic [LZW-1:0]       s2_lz;
  logic [IN_WIDTH-1:0]  s2_norm_d;
  logic [F32_EXP_W-1:0] s2_exp_d;

  logic                 out_valid_q;
  f32_t                 out_f_q;
  logic                 out_inexact_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  f32_t                 out_f_d;
  logic                 out_inexact_d;

  logic [EW-1:0]         s3_ext;
  logic [23:0]           s3_sig;
  logic                  s3_guard;
  logic                  s3_sticky;
  logic                  s3_inc;
  logic                  s3_zero;
  logic [F32_FRAC_W:0]   s3_frac_rnd;

  // The whole pipeline freezes, bubbles included, while the result is held.
  assign en       = !out_valid_q | OUT_READY;
  assign IN_READY = en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_valid_q  <= 1'b0;
      in_a_q      <= '0;
      in_signed_q <= 1'b0;
      in_rm_q     <= RM_RNE;
      in_tag_q    <= '0;
    end else if (en) begin
      in_valid_q  <= IN_VALID;
      in_a_q      <= IN_A;
      in_signed_q <= IN_SIGNED;
      in_rm_q     <= rmode_e'(IN_RMODE);
      in_tag_q    <= IN_TAG;
    end
  end

  // Negation wraps the most negative value onto 2^(IN_WIDTH-1) as unsigned.
  always_comb begin
    s1_sign_d = in_signed_q & in_a_q[IN_WIDTH-1];
    s1_mag_d  = s1_sign_d ? -in_a_q : in_a_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_rm_q    <= RM_RNE;
      s1_tag_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid_q;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_rm_q    <= in_rm_q;
      s1_tag_q   <= in_tag_q;
    end
  end

  fpu_lzc #(
    .WIDTH (IN_WIDTH),
    .CNT_W (LZW)
  ) u_lzc (
    .data_i (s1_mag_q),
    .lz_o   (s2_lz)
  );

  assign s2_norm_d = s1_mag_q << s2_lz;
  assign s2_exp_d  = 8'(F32_BIAS + IN_WIDTH - 1) - 8'(s2_lz);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_exp_q   <= '0;
      s2_rm_q    <= RM_RNE;
      s2_tag_q   <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_norm_q  <= s2_norm_d;
      s2_exp_q   <= s2_exp_d;
      s2_rm_q    <= s1_rm_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // A clear hidden bit after normalisation can only mean a zero operand.
  assign s3_ext      = {s2_norm_q, 26'd0};
  assign s3_sig      = s3_ext[EW-1 -: 24];
  assign s3_guard    = s3_ext[EW-25];
  assign s3_sticky   = |s3_ext[EW-26:0];
  assign s3_zero     = !s3_sig[23];
  assign s3_inc      = (s2_rm_q == RM_RNE) & s3_guard & (s3_sticky | s3_sig[0]);
  assign s3_frac_rnd = {1'b0, s3_sig[22:0]} + {{F32_FRAC_W{1'b0}}, s3_inc};

  always_comb begin
    out_f_d       = '0;
    out_inexact_d = 1'b0;
    if (!s3_zero) begin
      out_f_d.sign  = s2_sign_q;
      out_f_d.exp   = s2_exp_q + {{(F32_EXP_W-1){1'b0}}, s3_frac_rnd[F32_FRAC_W]};
      out_f_d.frac  = s3_frac_rnd[F32_FRAC_W-1:0];
      out_inexact_d = s3_guard | s3_sticky;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q   <= 1'b0;
      out_f_q       <= '0;
      out_inexact_q <= 1'b0;
      out_tag_q     <= '0;
    end else if (en) begin
      out_valid_q   <= s2_valid_q;
      out_f_q       <= out_f_d;
      out_inexact_q <= out_inexact_d;
      out_tag_q     <= s2_tag_q;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign OUT_F       = out_f_q;
  assign OUT_INEXACT = out_inexact_q;
  assign OUT_TAG     = out_tag_q;

endmodule

// File: tb/tb_fpu_int_to_f32_pipe.sv
// tb/tb_fpu_int_to_f32_pipe.sv - directed self-checking bench for fpu_int_to_f32_pipe
module tb_fpu_int_to_f32_pipe;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic        in_valid, in_ready, in_signed, in_rmode, out_valid, out_ready, out_inexact;
  logic [31:0] in_a, out_f;
  logic [3:0]  in_tag, out_tag;

  logic        h_in_valid, h_in_ready, h_in_signed, h_in_rmode, h_out_valid, h_out_ready, h_out_inexact;
  logic [15:0] h_in_a;
  logic [31:0] h_out_f;
  logic [3:0]  h_in_tag, h_out_tag;

  logic        w_in_valid, w_in_ready, w_in_signed, w_in_rmode, w_out_valid, w_out_ready, w_out_inexact;
  logic [63:0] w_in_a;
  logic [31:0] w_out_f;
  logic [3:0]  w_in_tag, w_out_tag;

  fpu_int_to_f32_pipe #(.IN_WIDTH(32), .TAG_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a),
    .IN_SIGNED(in_signed), .IN_RMODE(in_rmode), .IN_TAG(in_tag), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_F(out_f), .OUT_INEXACT(out_inexact), .OUT_TAG(out_tag)
  );

  fpu_int_to_f32_pipe #(.IN_WIDTH(16), .TAG_WIDTH(4)) dut16 (
    .CLK(CLK), .RST(RST), .IN_VALID(h_in_valid), .IN_READY(h_in_ready), .IN_A(h_in_a),
    .IN_SIGNED(h_in_signed), .IN_RMODE(h_in_rmode), .IN_TAG(h_in_tag), .OUT_VALID(h_out_valid),
    .OUT_READY(h_out_ready), .OUT_F(h_out_f), .OUT_INEXACT(h_out_inexact), .OUT_TAG(h_out_tag)
  );

  fpu_int_to_f32_pipe #(.IN_WIDTH(64), .TAG_WIDTH(4)) dut64 (
    .CLK(CLK), .RST(RST), .IN_VALID(w_in_valid), .IN_READY(w_in_ready), .IN_A(w_in_a),
    .IN_SIGNED(w_in_signed), .IN_RMODE(w_in_rmode), .IN_TAG(w_in_tag), .OUT_VALID(w_out_valid),
    .OUT_READY(w_out_ready), .OUT_F(w_out_f), .OUT_INEXACT(w_out_inexact), .OUT_TAG(w_out_tag)
  );

  // Hand-computed vectors for the 32-bit instance: operand, signed, rmode, result, inexact.
  logic [31:0] tv_a   [0:11] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h0000_0000,
                                 32'h0000_0000, 32'h0100_0003, 32'h7FFF_FFFF, 32'hFFFF_FF85};
  logic        tv_s   [0:11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        tv_rm  [0:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] tv_f   [0:11] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4F80_0000,
                                 32'h4F7F_FFFF, 32'h4B80_0000, 32'h4B80_0002, 32'h0000_0000,
                                 32'h0000_0000, 32'h4B80_0001, 32'h4F00_0000, 32'hC2F6_0000};
  logic        tv_inx [0:11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic test_reset();
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0 || out_f !== 32'h0 || out_inexact !== 1'b0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b f=%h inx=%b tag=%h, want 0 0 0 0", out_valid, out_f, out_inexact, out_tag);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || h_in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b%b, want 111", in_ready, h_in_ready, w_in_ready);
    end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_a = tv_a[i]; in_signed = tv_s[i];
      in_rmode = tv_rm[i]; in_tag = 4'(i);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge CLK); #1;
        lat++;
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles, want 3", i, lat);
      end
      checks++;
      if (out_f !== tv_f[i] || out_inexact !== tv_inx[i] || out_tag !== 4'(i)) begin
        errors++;
        $display("FAIL convert[%0d] a=%h: got f=%h inx=%b tag=%h, want f=%h inx=%b tag=%h",
                 i, tv_a[i], out_f, out_inexact, out_tag, tv_f[i], tv_inx[i], 4'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    int extra = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] f_prev = '0;
    logic [3:0]  tag_prev = '0;
    logic        inx_prev = 1'b0;
    for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
      @(posedge CLK); #1;
      if (stalled_prev) begin
        checks++;
        if (!out_valid || out_f !== f_prev || out_tag !== tag_prev || out_inexact !== inx_prev) begin
          errors++;
          $display("FAIL stall_hold: got v=%b f=%h tag=%h inx=%b, want v=1 f=%h tag=%h inx=%b",
                   out_valid, out_f, out_tag, out_inexact, f_prev, tag_prev, inx_prev);
        end
      end
      out_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in_valid = 1'b1; in_a = tv_a[sent]; in_signed = tv_s[sent];
        in_rmode = tv_rm[sent]; in_tag = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (out_tag !== 4'(rcvd) || out_f !== tv_f[rcvd] || out_inexact !== tv_inx[rcvd]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got tag=%h f=%h inx=%b, want tag=%h f=%h inx=%b",
                   rcvd, out_tag, out_f, out_inexact, 4'(rcvd), tv_f[rcvd], tv_inx[rcvd]);
        end
        rcvd++;
      end
      stalled_prev = out_valid && !out_ready;
      f_prev = out_f; tag_prev = out_tag; inx_prev = out_inexact;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (rcvd != 8 || sent != 8 || extra != 0) begin
      errors++;
      $display("FAIL bp_count: got sent=%0d rcvd=%0d extra=%0d, want 8 8 0", sent, rcvd, extra);
    end
  endtask

  task automatic test_widths();
    logic [15:0] ha [0:1] = '{16'hFFFF, 16'h0001};
    logic [31:0] hf [0:1] = '{32'h477F_FF00, 32'h3F80_0000};
    logic [63:0] wa [0:1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    logic        ws [0:1] = '{1'b0, 1'b1};
    logic        wr [0:1] = '{1'b1, 1'b0};
    logic [31:0] wf [0:1] = '{32'h5F7F_FFFF, 32'hDF00_0000};
    logic        wx [0:1] = '{1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      h_in_valid = 1'b1; h_in_a = ha[i]; h_in_signed = 1'b0; h_in_rmode = 1'b0; h_in_tag = 4'(i + 3);
      w_in_valid = 1'b1; w_in_a = wa[i]; w_in_signed = ws[i]; w_in_rmode = wr[i]; w_in_tag = 4'(i + 5);
      @(posedge CLK); #1;
      h_in_valid = 1'b0; w_in_valid = 1'b0;
      lat = 0;
      while (!(h_out_valid && w_out_valid) && lat < 10) begin
        @(posedge CLK); #1;
        lat++;
      end
      checks++;
      if (lat != 3 || h_out_f !== hf[i] || h_out_inexact !== 1'b0 || h_out_tag !== 4'(i + 3)) begin
        errors++;
        $display("FAIL w16[%0d]: got lat=%0d f=%h inx=%b tag=%h, want lat=3 f=%h inx=0 tag=%h",
                 i, lat, h_out_f, h_out_inexact, h_out_tag, hf[i], 4'(i + 3));
      end
      checks++;
      if (lat != 3 || w_out_f !== wf[i] || w_out_inexact !== wx[i] || w_out_tag !== 4'(i + 5)) begin
        errors++;
        $display("FAIL w64[%0d]: got lat=%0d f=%h inx=%b tag=%h, want lat=3 f=%h inx=%b tag=%h",
                 i, lat, w_out_f, w_out_inexact, w_out_tag, wf[i], wx[i], 4'(i + 5));
      end
    end
  endtask

  task automatic test_inflight_reset();
    int n32 = 0;
    int n16 = 0;
    int n64 = 0;
    logic [31:0] f32 = '0;
    logic [31:0] f16 = '0;
    logic [31:0] f64 = '0;
    out_ready = 1'b1; h_out_ready = 1'b1; w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1; in_a = tv_a[i + 3]; in_signed = tv_s[i + 3]; in_rmode = tv_rm[i + 3]; in_tag = 4'(i);
      h_in_valid = 1'b1; h_in_a = 16'h1234; h_in_signed = 1'b0; h_in_rmode = 1'b0; h_in_tag = 4'(i);
      w_in_valid = 1'b1; w_in_a = 64'h1234; w_in_signed = 1'b0; w_in_rmode = 1'b0; w_in_tag = 4'(i);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; h_in_valid = 1'b0; w_in_valid = 1'b0;
    RST = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || h_out_valid !== 1'b0 || w_out_valid !== 1'b0 || out_f !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b%b%b f=%h, want 000 f=00000000",
               out_valid, h_out_valid, w_out_valid, out_f);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b1; in_a = 32'h7FFF_FFFF; in_signed = 1'b1; in_rmode = 1'b0; in_tag = 4'h9;
    h_in_valid = 1'b1; h_in_a = 16'h8000; h_in_signed = 1'b1; h_in_rmode = 1'b0; h_in_tag = 4'hA;
    w_in_valid = 1'b1; w_in_a = 64'hFFFF_FFFF_FFFF_FFFF; w_in_signed = 1'b0; w_in_rmode = 1'b0; w_in_tag = 4'hB;
    @(posedge CLK); #1;
    in_valid = 1'b0; h_in_valid = 1'b0; w_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (out_valid)   begin n32++; f32 = out_f;   end
      if (h_out_valid) begin n16++; f16 = h_out_f; end
      if (w_out_valid) begin n64++; f64 = w_out_f; end
    end
    checks++;
    if (n32 != 1 || f32 !== 32'h4F00_0000) begin
      errors++;
      $display("FAIL post_reset_w32: got count=%0d f=%h, want count=1 f=4f000000", n32, f32);
    end
    checks++;
    if (n16 != 1 || f16 !== 32'hC700_0000) begin
      errors++;
      $display("FAIL post_reset_w16: got count=%0d f=%h, want count=1 f=c7000000", n16, f16);
    end
    checks++;
    if (n64 != 1 || f64 !== 32'h5F80_0000) begin
      errors++;
      $display("FAIL post_reset_w64: got count=%0d f=%h, want count=1 f=5f800000", n64, f64);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_signed = 1'b0; in_rmode = 1'b0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_signed = 1'b0; h_in_rmode = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_signed = 1'b0; w_in_rmode = 1'b0; w_in_tag = '0; w_out_ready = 1'b1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    test_reset();
    test_directed();
    test_backpressure();
    test_widths();
    test_inflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
